alu_seq_core: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational math and logic circuits.
- Performs add, sub, inc, and, or, nor, xor and multi-bit shift/rotate on W-bit operands.
- Produces carry, overflow, zero and negative flags.
- Shift/rotate by N executes iteratively, one bit per cycle.
- Sits between the register file and the writeback mux, with valid/ready handshakes on both sides.

---
 rtl/alu_seq_core.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq_core.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered W-bit ALU with flags and iterative shift/rotate.
// Valid/ready on both sides; the result is held until the consumer takes it.
module alu_seq_core #(
  parameter int W = 8,
  localparam int SHW = $clog2(W)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [3:0]     OP,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [SHW-1:0] SH,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [W-1:0]   R,
  output logic           C,
  output logic           V,
  output logic           Z,
  output logic           N,
  output logic           ERR
);

  if (W < 4 || (W & (W - 1)) != 0) begin : g_bad_w
    $error("alu_seq_core: W must be a power of two >= 4");
  end

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic           c_q, c_d;
  logic           v_q, v_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
  logic           err_q, err_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [3:0]     kind_q, kind_d;

  logic [W-1:0] bop;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] lo;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_v;
  logic         res_err;
  logic         is_shift;
  logic [W-1:0] step;
  logic         step_c;

  // SUB is A + ~B + 1, INC is A + 0 + 1; lo gives the carry into the MSB.
  assign bop = (OP == OP_SUB) ? ~B : (OP == OP_INC) ? '0 : B;
  assign cin = (OP == OP_SUB) || (OP == OP_INC);
  assign sum = {1'b0, A} + {1'b0, bop} + {{W{1'b0}}, cin};
  assign lo = {1'b0, A[W-2:0]} + {1'b0, bop[W-2:0]}
            + {{(W-1){1'b0}}, cin};
  assign is_shift = (OP >= OP_SHL) && (OP <= OP_ROR);

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (OP)
      OP_ADD, OP_SUB, OP_INC: begin
        res   = sum[W-1:0];
        res_c = sum[W];
        res_v = sum[W] ^ lo[W-1];
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_NOR: res = ~(A | B);
      OP_XOR: res = A ^ B;
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: res = A;
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    step   = {r_q[0], r_q[W-1:1]};
    step_c = r_q[0];
    case (kind_q)
      OP_SHL: begin
        step   = {r_q[W-2:0], 1'b0};
        step_c = r_q[W-1];
      end
      OP_SHR: begin
        step   = {1'b0, r_q[W-1:1]};
        step_c = r_q[0];
      end
      OP_ROL: begin
        step   = {r_q[W-2:0], r_q[W-1]};
        step_c = r_q[W-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          err_d = res_err;
          v_d   = 1'b0;
          if (is_shift && SH != '0) begin
            r_d     = A;
            c_d     = 1'b0;
            z_d     = 1'b0;
            n_d     = 1'b0;
            cnt_d   = SH;
            kind_d  = OP;
            state_d = S_SHIFT;
          end else begin
            r_d     = res;
            c_d     = res_c;
            v_d     = res_v;
            z_d     = (res == '0);
            n_d     = res[W-1];
            state_d = S_HOLD;
          end
        end
      end
      S_SHIFT: begin
        r_d   = step;
        c_d   = step_c;
        z_d   = (step == '0);
        n_d   = step[W-1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      kind_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE) && !RST;
  assign OUT_VALID = (state_q == S_HOLD);
  assign R   = r_q;
  assign C   = c_q;
  assign V   = v_q;
  assign Z   = z_q;
  assign N   = n_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: scoreboard bench for alu_seq_core at W=8 and W=16.
// Driver pushes expected results; a monitor pops them when OUT_VALID rises.
module tb_alu_seq_core;

  typedef struct {
    logic [15:0] r;
    logic c, v, z, n, e;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic [3:0] op = '0;
  logic [15:0] a = '0, b = '0;
  logic [3:0] sh = '0;
  logic iv8 = 1'b0, iv16 = 1'b0, ordy = 1'b1, sel = 1'b0;

  logic ir8, ov8, c8, v8, z8, n8, e8;
  logic [7:0] r8;
  logic ir16, ov16, c16, v16, z16, n16, e16;
  logic [15:0] r16;

  alu_seq_core #(.W(8)) u_dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8),
    .OP(op), .A(a[7:0]), .B(b[7:0]), .SH(sh[2:0]),
    .OUT_VALID(ov8), .OUT_READY(ordy), .R(r8),
    .C(c8), .V(v8), .Z(z8), .N(n8), .ERR(e8)
  );

  alu_seq_core #(.W(16)) u_dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(iv16), .IN_READY(ir16),
    .OP(op), .A(a), .B(b), .SH(sh),
    .OUT_VALID(ov16), .OUT_READY(ordy), .R(r16),
    .C(c16), .V(v16), .Z(z16), .N(n16), .ERR(e16)
  );

  logic ir, ov, fc, fv, fz, fn, fe;
  logic [15:0] rr;
  assign ir = sel ? ir16 : ir8;
  assign ov = sel ? ov16 : ov8;
  assign rr = sel ? r16 : {8'h00, r8};
  assign fc = sel ? c16 : c8;
  assign fv = sel ? v16 : v8;
  assign fz = sel ? z16 : z8;
  assign fn = sel ? n16 : n8;
  assign fe = sel ? e16 : e8;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t cur;
  logic pov = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, v, z,
                              n, e, input int lat);
    exp_t x;
    x.r = r; x.c = c; x.v = v; x.z = z; x.n = n; x.e = e;
    x.lat = lat; x.acc = 0;
    return x;
  endfunction

  // Independent 16-bit reference: whole-word shifts, sign-based overflow.
  function automatic exp_t model16(input logic [3:0] o,
                                   input logic [15:0] x, y,
                                   input logic [3:0] s);
    exp_t m;
    logic [16:0] t;
    int k;
    m = mk(16'h0, 0, 0, 0, 0, 0, 1);
    k = int'(s);
    case (o)
      4'd0: begin
        t = x + y; m.r = t[15:0]; m.c = t[16];
        m.v = (x[15] == y[15]) && (m.r[15] != x[15]);
      end
      4'd1: begin
        t = {1'b0, x} + {1'b0, ~y} + 17'd1; m.r = t[15:0]; m.c = t[16];
        m.v = (x[15] != y[15]) && (m.r[15] != x[15]);
      end
      4'd2: m.r = x & y;
      4'd3: m.r = x | y;
      4'd4: m.r = ~(x | y);
      4'd5: m.r = x ^ y;
      4'd6: if (k == 0) m.r = x;
            else begin m.r = x << k; m.c = x[16-k]; end
      4'd7: if (k == 0) m.r = x;
            else begin m.r = x >> k; m.c = x[k-1]; end
      4'd8: if (k == 0) m.r = x;
            else begin m.r = (x << k) | (x >> (16 - k)); m.c = m.r[0]; end
      4'd9: if (k == 0) m.r = x;
            else begin m.r = (x >> k) | (x << (16 - k)); m.c = m.r[15]; end
      4'd10: begin
        t = x + 17'd1; m.r = t[15:0]; m.c = t[16];
        m.v = (x == 16'h7FFF);
      end
      default: m.e = 1'b1;
    endcase
    m.z = (m.r == 16'h0);
    m.n = m.r[15];
    if (o >= 4'd6 && o <= 4'd9 && k != 0) m.lat = k + 1;
    return m;
  endfunction

  // Monitor: compare on the rising edge of OUT_VALID, then check it holds.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ov && !pov) begin
        if (q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          cur = q.pop_front();
          chk("R", rr, cur.r);
          chk("C", 16'(fc), 16'(cur.c));
          chk("V", 16'(fv), 16'(cur.v));
          chk("Z", 16'(fz), 16'(cur.z));
          chk("N", 16'(fn), 16'(cur.n));
          chk("ERR", 16'(fe), 16'(cur.e));
          chk("latency", 16'(cyc - cur.acc + 1), 16'(cur.lat));
        end
      end else if (ov && pov) begin
        chk("hold_R", rr, cur.r);
        chk("hold_in_ready", 16'(ir), 16'h0);
      end
      pov = ov;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] x, y,
                       input logic [3:0] s, input exp_t e, input bit push);
    int t;
    op = o; a = x; b = y; sh = s;
    iv8 = !sel; iv16 = sel;
    t = 0;
    while (!ir && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!ir) begin
      fail_now("in_ready_timeout");
      iv8 = 1'b0; iv16 = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv16 = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    sh = 4'($urandom);
  endtask

  task automatic d8(input logic [3:0] o, input logic [7:0] x, y,
                    input logic [3:0] s, input logic [7:0] r,
                    input logic c, v, z, n, e, input int lat);
    issue(o, {8'h0, x}, {8'h0, y}, s, mk({8'h0, r}, c, v, z, n, e, lat), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || ov) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0 || ov) fail_now("drain_timeout");
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_R"}, rr, 16'h0);
    chk({nm, "_flags"}, {11'h0, fc, fv, fz, fn, fe}, 16'h0);
    chk({nm, "_out_valid"}, 16'(ov), 16'h0);
  endtask

  initial begin
    logic [3:0] shl[4];
    exp_t m;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    chk_zero("rst8");
    chk("rst8_in_ready", 16'(ir), 16'h0);
    sel = 1'b1;
    chk_zero("rst16");
    sel = 1'b0;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 16'(ir), 16'h1);

    //   op    A      B      SH    R      C  V  Z  N  E  lat
    d8(4'd0,  8'h7F, 8'h01, 4'd0, 8'h80, 0, 1, 0, 1, 0, 1);
    d8(4'd1,  8'h05, 8'h05, 4'd0, 8'h00, 1, 0, 1, 0, 0, 1);
    d8(4'd10, 8'hFF, 8'h00, 4'd0, 8'h00, 1, 0, 1, 0, 0, 1);
    d8(4'd8,  8'h81, 8'h00, 4'd3, 8'h0C, 0, 0, 0, 0, 0, 4);
    d8(4'd7,  8'h81, 8'h00, 4'd1, 8'h40, 1, 0, 0, 0, 0, 2);
    d8(4'd1,  8'h00, 8'h01, 4'd0, 8'hFF, 0, 0, 0, 1, 0, 1);
    d8(4'd1,  8'h80, 8'h01, 4'd0, 8'h7F, 1, 1, 0, 0, 0, 1);
    d8(4'd0,  8'h80, 8'h80, 4'd0, 8'h00, 1, 1, 1, 0, 0, 1);
    d8(4'd0,  8'hFF, 8'h01, 4'd0, 8'h00, 1, 0, 1, 0, 0, 1);
    d8(4'd10, 8'h7F, 8'h33, 4'd0, 8'h80, 0, 1, 0, 1, 0, 1);
    d8(4'd2,  8'hA5, 8'h0F, 4'd0, 8'h05, 0, 0, 0, 0, 0, 1);
    d8(4'd3,  8'hA0, 8'h05, 4'd0, 8'hA5, 0, 0, 0, 1, 0, 1);
    d8(4'd4,  8'h00, 8'h00, 4'd0, 8'hFF, 0, 0, 0, 1, 0, 1);
    d8(4'd4,  8'hFF, 8'h00, 4'd0, 8'h00, 0, 0, 1, 0, 0, 1);
    d8(4'd9,  8'h01, 8'h00, 4'd1, 8'h80, 1, 0, 0, 1, 0, 2);
    d8(4'd6,  8'h03, 8'h00, 4'd7, 8'h80, 1, 0, 0, 1, 0, 8);
    d8(4'd6,  8'h81, 8'h00, 4'd7, 8'h80, 0, 0, 0, 1, 0, 8);
    d8(4'd6,  8'h55, 8'h00, 4'd0, 8'h55, 0, 0, 0, 0, 0, 1);
    d8(4'd9,  8'h80, 8'h00, 4'd0, 8'h80, 0, 0, 0, 1, 0, 1);
    d8(4'd13, 8'h12, 8'h34, 4'd0, 8'h00, 0, 0, 1, 0, 1, 1);
    drain();

    // Backpressure: result must hold for five stalled cycles.
    ordy = 1'b0;
    d8(4'd5, 8'hF0, 8'hFF, 4'd0, 8'h0F, 0, 0, 0, 0, 0, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid", 16'(ov), 16'h1);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_handoff", 16'(ir), 16'h1);
    chk("ov_after_handoff", 16'(ov), 16'h0);

    // Reset in the middle of a long shift: nothing may come out.
    issue(4'd6, 16'h00FF, 16'h0, 4'd7, mk(0, 0, 0, 0, 0, 0, 0), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("in_ready_in_rst", 16'(ir), 16'h0);
    @(posedge clk);
    #1;
    chk_zero("mid_shift_rst");
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    d8(4'd0, 8'h01, 8'h02, 4'd0, 8'h03, 0, 0, 0, 0, 0, 1);
    drain();

    // W=16 sweep of every opcode against the reference model.
    sel = 1'b1;
    @(posedge clk);
    #1;
    for (int o = 0; o < 16; o++) begin
      shl[0] = 4'd0; shl[1] = 4'd15; shl[2] = 4'd1;
      shl[3] = 4'($urandom_range(2, 14));
      for (int k = 0; k < 4; k++) begin
        logic [15:0] x, y;
        x = 16'($urandom);
        y = 16'($urandom);
        if (k == 0 && o == 1) y = x;
        if (k == 1 && o == 10) x = 16'h7FFF;
        m = model16(4'(o), x, y, shl[k]);
        issue(4'(o), x, y, shl[k], m, 1);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
